// File: rtl/lin_interp_sched_if.sv
// rtl/lin_interp_sched_if.sv - IQ input stream and operand-pair output stream of the interpolator scheduler
interface lin_interp_sched_if #(
  parameter int DATA_WIDTH = 16
);
  logic [2*DATA_WIDTH-1:0] in_tdata;
  logic                    in_tvalid;
  logic                    in_tlast;
  logic                    in_tready;
  logic [2*DATA_WIDTH-1:0] out0_tdata;
  logic [2*DATA_WIDTH-1:0] out1_tdata;
  logic [DATA_WIDTH-1:0]   scale0_tdata;
  logic [DATA_WIDTH-1:0]   scale1_tdata;
  logic                    out_tvalid;
  logic                    out_tlast;
  logic                    out_tready;

  modport master (
    output in_tdata, in_tvalid, in_tlast, out_tready,
    input  in_tready, out0_tdata, out1_tdata, scale0_tdata, scale1_tdata, out_tvalid, out_tlast
  );

  modport slave (
    input  in_tdata, in_tvalid, in_tlast, out_tready,
    output in_tready, out0_tdata, out1_tdata, scale0_tdata, scale1_tdata, out_tvalid, out_tlast
  );
endinterface

// File: rtl/lin_interp_sched.sv
// rtl/lin_interp_sched.sv - phase-accumulator scheduler issuing sample pairs and Q1.15 weights at a fractional step
// Optional LIN_INTERP_SCHED_PHASE_EN adds cfg_phase_i as the initial fraction of each burst.
module lin_interp_sched #(
  parameter int DATA_WIDTH = 16,
  parameter int STEP_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic [STEP_WIDTH-1:0] cfg_step_i,
`ifdef LIN_INTERP_SCHED_PHASE_EN
  input  logic [STEP_WIDTH-2:0] cfg_phase_i,
`endif
  output logic                  busy_o,
  lin_interp_sched_if.slave     bus
);
  localparam int FW = STEP_WIDTH - 1;
  localparam int SW = 2 * DATA_WIDTH;
  localparam logic [STEP_WIDTH-1:0] STEP_ONE = {1'b1, {FW{1'b0}}};
  localparam logic [FW:0] W_ONE = {1'b1, {FW{1'b0}}};
  localparam logic [FW:0] W_MAX = {1'b0, {FW{1'b1}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e                 state_q, state_d;
  logic [SW-1:0]          s0_q, s0_d, s1_q, s1_d;
  logic [1:0]             ip_q, ip_d;
  logic [FW-1:0]          f_q, f_d;
  logic [STEP_WIDTH-1:0]  step_q, step_d;
  logic                   rdy_q;
  logic [SW-1:0]          o0_q, o0_d, o1_q, o1_d;
  logic [DATA_WIDTH-1:0]  sc0_q, sc0_d, sc1_q, sc1_d;
  logic                   ov_q, ov_d, ol_q, ol_d;

  logic [FW+1:0]          pos_sum, pos_a;
  logic [1:0]             ip_a;
  logic [FW-1:0]          f_a;
  logic [FW:0]            w0;
  logic                   out_free, emit, in_rdy;

  always_comb begin
    pos_sum  = {ip_q, f_q} + {1'b0, step_q};
    out_free = !ov_q || bus.out_tready;
    emit     = (state_q != IDLE) && (ip_q == 2'd0) && out_free;
    pos_a    = emit ? pos_sum : {ip_q, f_q};
    ip_a     = pos_a[FW+1:FW];
    f_a      = pos_a[FW-1:0];
    w0       = (f_q == '0) ? W_MAX : (W_ONE - {1'b0, f_q});

    state_d = state_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    ip_d    = ip_q;
    f_d     = f_q;
    step_d  = step_q;
    o0_d    = o0_q;
    o1_d    = o1_q;
    sc0_d   = sc0_q;
    sc1_d   = sc1_q;
    ov_d    = ov_q && !bus.out_tready;
    ol_d    = ol_q;
    in_rdy  = 1'b0;

    if (emit) begin
      o0_d  = s0_q;
      o1_d  = s1_q;
      sc0_d = DATA_WIDTH'(w0);
      sc1_d = DATA_WIDTH'(f_q);
      ov_d  = 1'b1;
      ol_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        in_rdy = rdy_q;
        if (bus.in_tvalid && rdy_q) begin
          if (bus.in_tlast) begin
            // A lone sample drains through the single (s1,s1) emit, so it yields exactly one output.
            s0_d    = bus.in_tdata;
            s1_d    = bus.in_tdata;
            ip_d    = 2'd1;
            f_d     = '0;
            state_d = DRAIN;
          end else begin
            s1_d   = bus.in_tdata;
            step_d = (cfg_step_i == '0) ? STEP_ONE : cfg_step_i;
            ip_d   = 2'd1;
`ifdef LIN_INTERP_SCHED_PHASE_EN
            f_d    = cfg_phase_i;
`else
            f_d    = '0;
`endif
            state_d = RUN;
          end
        end
      end
      RUN: begin
        in_rdy = (ip_a != 2'd0);
        ip_d   = ip_a;
        f_d    = f_a;
        if (bus.in_tvalid && in_rdy) begin
          s0_d = s1_q;
          s1_d = bus.in_tdata;
          ip_d = ip_a - 2'd1;
          if (bus.in_tlast) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (ip_q != 2'd0) begin
          if (out_free) begin
            o0_d    = s1_q;
            o1_d    = s1_q;
            sc0_d   = DATA_WIDTH'(W_MAX);
            sc1_d   = '0;
            ov_d    = 1'b1;
            ol_d    = 1'b1;
            ip_d    = 2'd0;
            f_d     = '0;
            state_d = IDLE;
          end
        end else begin
          ip_d = ip_a;
          f_d  = f_a;
          // The last pair is done once the phase would step past the newer sample.
          if (emit && (ip_a != 2'd0)) begin
            ol_d    = 1'b1;
            ip_d    = 2'd0;
            f_d     = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      s0_q    <= '0;
      s1_q    <= '0;
      ip_q    <= '0;
      f_q     <= '0;
      step_q  <= '0;
      rdy_q   <= 1'b0;
      o0_q    <= '0;
      o1_q    <= '0;
      sc0_q   <= '0;
      sc1_q   <= '0;
      ov_q    <= 1'b0;
      ol_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      ip_q    <= ip_d;
      f_q     <= f_d;
      step_q  <= step_d;
      rdy_q   <= 1'b1;
      o0_q    <= o0_d;
      o1_q    <= o1_d;
      sc0_q   <= sc0_d;
      sc1_q   <= sc1_d;
      ov_q    <= ov_d;
      ol_q    <= ol_d;
    end
  end

  assign bus.in_tready    = in_rdy;
  assign bus.out0_tdata   = o0_q;
  assign bus.out1_tdata   = o1_q;
  assign bus.scale0_tdata = sc0_q;
  assign bus.scale1_tdata = sc1_q;
  assign bus.out_tvalid   = ov_q;
  assign bus.out_tlast    = ol_q;
  assign busy_o           = (state_q != IDLE);
endmodule

// File: tb/tb_lin_interp_sched.sv
// tb/tb_lin_interp_sched.sv - directed bench for lin_interp_sched with a captured-output scoreboard
module tb_lin_interp_sched;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] cfg_step;
  logic        busy;
  int          n_checks = 0;
  int          n_pass = 0;

  typedef struct {
    logic [31:0] o0;
    logic [31:0] o1;
    logic [15:0] s0;
    logic [15:0] s1;
    logic        last;
  } rec_t;

  rec_t got_q[$];
  rec_t exp_q[$];

  lin_interp_sched_if #(.DATA_WIDTH(16)) bus ();

  lin_interp_sched #(.DATA_WIDTH(16), .STEP_WIDTH(16)) dut (
    .clk_i      (clk),
    .reset_n_i  (reset_n),
    .cfg_step_i (cfg_step),
    .busy_o     (busy),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset_n && bus.out_tvalid && bus.out_tready)
      got_q.push_back('{bus.out0_tdata, bus.out1_tdata, bus.scale0_tdata, bus.scale1_tdata, bus.out_tlast});
  end

  function automatic logic [31:0] samp(input int k);
    return {16'(k), 16'(k + 256)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic exp_push(input int a, input int b, input int w0, input int w1, input bit last);
    exp_q.push_back('{samp(a), samp(b), 16'(w0), 16'(w1), last});
  endtask

  task automatic compare(input string nm);
    chk({nm, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s_out0[%0d]", nm, i), got_q[i].o0, exp_q[i].o0);
      chk($sformatf("%s_out1[%0d]", nm, i), got_q[i].o1, exp_q[i].o1);
      chk($sformatf("%s_scale0[%0d]", nm, i), 32'(got_q[i].s0), 32'(exp_q[i].s0));
      chk($sformatf("%s_scale1[%0d]", nm, i), 32'(got_q[i].s1), 32'(exp_q[i].s1));
      chk($sformatf("%s_tlast[%0d]", nm, i), 32'(got_q[i].last), 32'(exp_q[i].last));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic send_burst(input int first, input int n, input int gap, input bit with_last,
                            output int stalls);
    stalls = 0;
    for (int k = 0; k < n; k++) begin
      int w;
      bit ok;
      bus.in_tvalid = 1'b1;
      bus.in_tdata  = samp(first + k);
      bus.in_tlast  = with_last && (k == n - 1);
      w  = 0;
      ok = 1'b0;
      while (!ok && w <= 50) begin
        @(negedge clk);
        if (bus.in_tready) ok = 1'b1;
        else begin
          stalls++;
          w++;
        end
      end
      if (!ok) begin
        chk("accept_timeout", 32'(bus.in_tready), 32'd1);
        bus.in_tvalid = 1'b0;
        bus.in_tlast  = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      if (gap > 0) begin
        bus.in_tvalid = 1'b0;
        bus.in_tlast  = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    bus.in_tvalid = 1'b0;
    bus.in_tlast  = 1'b0;
  endtask

  task automatic wait_idle();
    int  w;
    bit  done;
    w    = 0;
    done = 1'b0;
    while (!done && w < 200) begin
      @(negedge clk);
      if (!busy && !bus.out_tvalid) done = 1'b1;
      w++;
    end
    if (!done) chk("idle_timeout", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic push_a_expect();
    exp_push(1, 2, 32767, 0, 0);
    exp_push(2, 3, 24576, 8192, 0);
    exp_push(3, 4, 16384, 16384, 0);
    exp_push(4, 5, 8192, 24576, 0);
    exp_push(6, 7, 32767, 0, 0);
    exp_push(7, 8, 24576, 8192, 0);
    exp_push(8, 9, 16384, 16384, 0);
    exp_push(9, 10, 8192, 24576, 1);
  endtask

  initial begin
    int st;
    reset_n        = 1'b0;
    cfg_step       = 16'hA000;
    bus.in_tvalid  = 1'b0;
    bus.in_tlast   = 1'b0;
    bus.in_tdata   = '0;
    bus.out_tready = 1'b1;

    #2;
    chk("rst_in_tready", 32'(bus.in_tready), 0);
    chk("rst_out_tvalid", 32'(bus.out_tvalid), 0);
    chk("rst_out_tlast", 32'(bus.out_tlast), 0);
    chk("rst_out0", bus.out0_tdata, 0);
    chk("rst_scale0", 32'(bus.scale0_tdata), 0);
    chk("rst_busy", 32'(busy), 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    #1 chk("post_rst_in_tready_low", 32'(bus.in_tready), 0);
    @(posedge clk);
    #1 chk("post_rst_in_tready_high", 32'(bus.in_tready), 1);

    push_a_expect();
    send_burst(1, 10, 0, 1'b1, st);
    chk("A_stalls", 32'(st), 0);
    wait_idle();
    compare("A");

    cfg_step = 16'h4000;
    exp_push(1, 2, 32767, 0, 0);
    exp_push(1, 2, 16384, 16384, 0);
    exp_push(2, 3, 32767, 0, 0);
    exp_push(2, 3, 16384, 16384, 1);
    send_burst(1, 3, 0, 1'b1, st);
    chk("B_stalls", 32'(st), 1);
    wait_idle();
    compare("B");

    exp_push(7, 7, 32767, 0, 1);
    send_burst(7, 1, 0, 1'b1, st);
    wait_idle();
    compare("SINGLE");

    cfg_step = 16'h0000;
    exp_push(1, 2, 32767, 0, 0);
    exp_push(2, 3, 32767, 0, 0);
    exp_push(3, 4, 32767, 0, 1);
    send_burst(1, 4, 2, 1'b1, st);
    wait_idle();
    compare("ZSTEP");

    cfg_step = 16'hA000;
    push_a_expect();
    fork
      send_burst(1, 10, 0, 1'b1, st);
      begin
        repeat (4) @(posedge clk);
        #1 bus.out_tready = 1'b0;
        repeat (5) @(negedge clk);
        chk("BP_out_tvalid", 32'(bus.out_tvalid), 1);
        chk("BP_in_tready", 32'(bus.in_tready), 0);
        chk("BP_busy", 32'(busy), 1);
        @(posedge clk);
        #1 bus.out_tready = 1'b1;
      end
    join
    wait_idle();
    compare("BP");

    cfg_step = 16'h4000;
    send_burst(1, 2, 0, 1'b0, st);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("MRST_out_tvalid", 32'(bus.out_tvalid), 0);
    chk("MRST_out0", bus.out0_tdata, 0);
    chk("MRST_scale0", 32'(bus.scale0_tdata), 0);
    chk("MRST_in_tready", 32'(bus.in_tready), 0);
    chk("MRST_busy", 32'(busy), 0);
    got_q.delete();
    @(posedge clk);
    #1 reset_n = 1'b1;
    cfg_step = 16'hA000;
    exp_push(21, 22, 32767, 0, 0);
    exp_push(22, 23, 24576, 8192, 1);
    send_burst(21, 3, 0, 1'b1, st);
    wait_idle();
    compare("RST");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
